mem_stage_access_ctrl: RTL and testbench
========================================

Name: mem_stage_access_ctrl

Overview:
- MEM-stage responder on the far side of the EX/MEM pipeline register.
- Consumes PR3 memory-control signals, address and store data, and runs a variable-latency req/ack transaction to data memory.
- Stalls the upstream pipeline while the access is in flight.
- Presents load data for one cycle to the MEM/WB register.

Parameters:
- WORD_LEN, 8, data width of loads and stores.
- ADDR_LEN, 8, memory address width; address = PR3_alu_out[ADDR_LEN-1:0].
- TIMEOUT, 15, maximum ACCESS cycles without ack before abort; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- PR3_MEM_read  in  1  load request from EX/MEM register.
- PR3_MEM_write  in  1  store request from EX/MEM register.
- PR3_alu_out  in  WORD_LEN  effective address.
- PR3_RF_out2  in  WORD_LEN  store data.
- mem_req  out  1  transaction request to data memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_LEN  access address.
- mem_wdata  out  WORD_LEN  write data.
- mem_ack  in  1  memory completion strobe, one cycle.
- mem_rdata  in  WORD_LEN  read data; valid with mem_ack.
- mem_stall  out  1  freeze PC/PR1/PR2/PR3.
- MEM_read_data  out  WORD_LEN  load result for MEM/WB.
- MEM_data_valid  out  1  MEM_read_data valid this cycle.
- mem_timeout  out  1  sticky: an access aborted on timeout.
- mem_conflict  out  1  sticky: read and write asserted together.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE;
  - mem_req, mem_we, mem_stall, MEM_data_valid, mem_timeout, mem_conflict = 0;
  - mem_addr, mem_wdata, MEM_read_data = 0;
  - cycle counter = 0.
- Reset asserted mid-ACCESS drops mem_req immediately. Any later ack is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If (PR3_MEM_read | PR3_MEM_write):
    - mem_stall=1 combinationally.
    - Next edge: capture addr/wdata, set mem_we = PR3_MEM_write, mem_req=1, counter=0, go ACCESS.
  - Otherwise mem_stall=0 and stay IDLE.
- ACCESS:
  - mem_stall=1.
  - mem_req, mem_we, mem_addr, mem_wdata are registered and held stable.
  - On mem_ack:
    - mem_req←0.
    - For a read, MEM_read_data←mem_rdata.
    - Go DONE.
  - If no ack and counter==TIMEOUT-1:
    - mem_req←0, mem_timeout←1.
    - MEM_read_data←all ones for a read.
    - Go DONE.
  - Otherwise counter increments.
- DONE:
  - mem_stall=0.
  - MEM_data_valid=1 for exactly this cycle, only if the access was a read.
  - The pipeline advances on this edge; next state is always IDLE. This guarantees no double issue of the same PR3 instruction.
- Latency: ack in first ACCESS cycle → 2 stall cycles, data valid in the 3rd cycle. Each extra ack delay adds one stall cycle.
- Read and write both asserted in IDLE: write wins (mem_we=1), mem_conflict←1 (sticky), no MEM_data_valid.
- mem_ack in IDLE or DONE: ignored, no state or data change.
- MEM_read_data holds its last value outside DONE. Writes never modify it.
- Sticky flags clear only on reset.
- Counter width: ceil(log2(TIMEOUT))+1 bits. No wrap, because it is reset on each request.

Test Plan:
- Reset release, PR3_MEM_read=0, PR3_MEM_write=0 for 10 cycles → mem_req=0, mem_stall=0 throughout, all outputs 0.
- Load addr 0x12, memory acks in the 1st ACCESS cycle with rdata 0xA5 → mem_req high 1 cycle with mem_we=0 and mem_addr=0x12; mem_stall high 2 cycles; MEM_data_valid=1 with 0xA5 in the 3rd cycle.
- Store 0x3C to 0x40, ack after 4 cycles → mem_we=1, wdata=0x3C held for 4 ACCESS cycles; 5 stall cycles; MEM_data_valid never asserts; MEM_read_data unchanged.
- Load, never acked, TIMEOUT=15 → mem_req drops after 15 ACCESS cycles; mem_timeout=1; MEM_read_data=0xFF valid for one cycle; next load proceeds normally and mem_timeout stays 1.
- Back-to-back loads (addr 0x01 then 0x02, immediate acks) → two distinct requests; IDLE cycle between DONE and the second ACCESS; no duplicate request for 0x01.
- Both read and write asserted → write issued, mem_conflict=1. In a separate run, rst pulsed low mid-ACCESS → mem_req=0 immediately; a later ack causes no DONE and no data valid.

Source files
------------

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_access_ctrl
// Purpose : MEM-stage req/ack data-memory access controller with pipeline stall
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_access_ctrl #(
  parameter int WORD_LEN = 8,
  parameter int ADDR_LEN = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PR3_MEM_read,
  input  logic                PR3_MEM_write,
  input  logic [WORD_LEN-1:0] PR3_alu_out,
  input  logic [WORD_LEN-1:0] PR3_RF_out2,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_stall,
  output logic [WORD_LEN-1:0] MEM_read_data,
  output logic                MEM_data_valid,
  output logic                mem_timeout,
  output logic                mem_conflict
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start;

  assign w_start = PR3_MEM_read | PR3_MEM_write;

  // Stall asserts in the same cycle a request appears so PR3 is held for capture.
  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      IDLE:    mem_stall = w_start;
      ACCESS:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      MEM_read_data  <= '0;
      MEM_data_valid <= 1'b0;
      mem_timeout    <= 1'b0;
      mem_conflict   <= 1'b0;
    end else begin
      MEM_data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            mem_req   <= 1'b1;
            mem_we    <= PR3_MEM_write;
            mem_addr  <= PR3_alu_out[ADDR_LEN-1:0];
            mem_wdata <= PR3_RF_out2;
            r_cnt     <= '0;
            r_state   <= ACCESS;
            if (PR3_MEM_read && PR3_MEM_write) begin
              mem_conflict <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              MEM_read_data  <= mem_rdata;
              MEM_data_valid <= 1'b1;
            end
            r_state <= DONE;
          end else if (r_cnt == c_last) begin
            // Aborted loads return all ones so a consumer sees a recognisable value.
            mem_req     <= 1'b0;
            mem_timeout <= 1'b1;
            if (!mem_we) begin
              MEM_read_data  <= '1;
              MEM_data_valid <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_access_ctrl
// Purpose : Self-checking bench: directed vector table plus randomized txns
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage_access_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       PR3_MEM_read, PR3_MEM_write;
  logic [7:0] PR3_alu_out, PR3_RF_out2;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       mem_stall;
  logic [7:0] MEM_read_data;
  logic       MEM_data_valid, mem_timeout, mem_conflict;

  mem_stage_access_ctrl #(.WORD_LEN(8), .ADDR_LEN(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .PR3_MEM_read(PR3_MEM_read), .PR3_MEM_write(PR3_MEM_write),
    .PR3_alu_out(PR3_alu_out), .PR3_RF_out2(PR3_RF_out2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .MEM_read_data(MEM_read_data), .MEM_data_valid(MEM_data_valid),
    .mem_timeout(mem_timeout), .mem_conflict(mem_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;      // ack in this ACCESS cycle (1-based); 0 = never
    logic [7:0] rdata;
    int         exp_stall;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_to;
    logic       exp_cf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last delivered load data and sticky flags.
  logic [7:0] m_data;
  logic       m_to, m_cf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input int delay, input logic [7:0] rdata,
                              input int es, input logic ev, input logic [7:0] ed,
                              input logic eto, input logic ecf);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay; v.rdata = rdata;
    v.exp_stall = es; v.exp_valid = ev; v.exp_data = ed; v.exp_to = eto; v.exp_cf = ecf;
    return v;
  endfunction

  // Transaction-level prediction: stall length, load result and flags follow from
  // whether the ack arrives within the timeout window.
  function automatic vec_t predict(input logic rd, input logic wr, input logic [7:0] addr,
                                   input logic [7:0] wdata, input int delay, input logic [7:0] rdata);
    vec_t v;
    bit   acked = (delay >= 1) && (delay <= TO);
    bit   is_rd = rd && !wr;
    if (is_rd) m_data = acked ? rdata : 8'hFF;
    if (!acked) m_to = 1'b1;
    if (rd && wr) m_cf = 1'b1;
    v = mk(rd, wr, addr, wdata, delay, rdata, 1 + (acked ? delay : TO), is_rd, m_data, m_to, m_cf);
    return v;
  endfunction

  task automatic idle_cycle();
    PR3_MEM_read = 1'b0; PR3_MEM_write = 1'b0;
    PR3_alu_out = 8'($urandom); PR3_RF_out2 = 8'($urandom);
    mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
    #2;
    chk("idle_stall", mem_stall, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_valid", MEM_data_valid, 0);
    chk("idle_data_hold", MEM_read_data, m_data);
    chk("idle_timeout", mem_timeout, m_to);
    chk("idle_conflict", mem_conflict, m_cf);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int stalls = 0;
    PR3_MEM_read = v.rd; PR3_MEM_write = v.wr;
    PR3_alu_out = v.addr; PR3_RF_out2 = v.wdata;
    mem_ack = 1'b0;
    #2;
    chk("req_before_issue", mem_req, 0);
    if (mem_stall) stalls++;
    for (int k = 1; k <= TO + 2; k++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      #1;
      if (!mem_stall) break;
      stalls++;
      chk("access_req", mem_req, 1);
      chk("access_we", mem_we, v.wr);
      chk("access_addr", mem_addr, v.addr);
      chk("access_wdata", mem_wdata, v.wdata);
      if (k == v.delay) begin mem_ack = 1'b1; mem_rdata = v.rdata; end
    end
    chk("stall_cycles", stalls, v.exp_stall);
    chk("done_req", mem_req, 0);
    chk("done_valid", MEM_data_valid, v.exp_valid);
    chk("done_data", MEM_read_data, v.exp_data);
    chk("done_timeout", mem_timeout, v.exp_to);
    chk("done_conflict", mem_conflict, v.exp_cf);
    // A stray ack in DONE must be ignored.
    mem_ack = 1'b1; mem_rdata = 8'($urandom);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    PR3_MEM_read = 1'b0; PR3_MEM_write = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    rst = 1'b0;
    PR3_MEM_read = 0; PR3_MEM_write = 0; PR3_alu_out = 0; PR3_RF_out2 = 0;
    mem_ack = 0; mem_rdata = 0;
    m_data = 8'h00; m_to = 0; m_cf = 0;

    tbl[0] = mk(1, 0, 8'h12, 8'h00, 1,  8'hA5, 2,  1, 8'hA5, 0, 0);
    tbl[1] = mk(0, 1, 8'h40, 8'h3C, 4,  8'h99, 5,  0, 8'hA5, 0, 0);
    tbl[2] = mk(1, 0, 8'h55, 8'h00, 0,  8'h00, 16, 1, 8'hFF, 1, 0);
    tbl[3] = mk(1, 0, 8'h01, 8'h00, 1,  8'h11, 2,  1, 8'h11, 1, 0);
    tbl[4] = mk(1, 0, 8'h02, 8'h00, 1,  8'h22, 2,  1, 8'h22, 1, 0);
    tbl[5] = mk(1, 1, 8'h33, 8'h77, 2,  8'h44, 3,  0, 8'h22, 1, 1);
    tbl[6] = mk(1, 0, 8'h7E, 8'h00, TO, 8'h5A, 16, 1, 8'h5A, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_data", MEM_read_data, 0);
    chk("rst_valid", MEM_data_valid, 0);
    chk("rst_flags", {mem_timeout, mem_conflict}, 0);
    rst = 1'b1;
    repeat (10) idle_cycle();

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i]);
      m_data = tbl[i].exp_data; m_to = tbl[i].exp_to; m_cf = tbl[i].exp_cf;
    end
    repeat (2) idle_cycle();

    // Reset in the middle of an access.
    PR3_MEM_read = 1; PR3_MEM_write = 0; PR3_alu_out = 8'h99;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_req", mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_flags", {mem_timeout, mem_conflict}, 0);
    chk("async_rst_data", MEM_read_data, 0);
    PR3_MEM_read = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_data = 8'h00; m_to = 0; m_cf = 0;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    #2;
    chk("late_ack_stall", mem_stall, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) idle_cycle();

    for (int i = 0; i < 40; i++) begin
      int         sel   = int'($urandom_range(1, 3));
      int         delay = int'($urandom_range(0, TO + 2));
      logic [7:0] a     = 8'($urandom);
      logic [7:0] wd    = 8'($urandom);
      logic [7:0] rd    = 8'($urandom);
      run_txn(predict(sel[0], sel[1], a, wd, delay, rd));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
